// File: rtl/matrix_stream_loader.sv
// Assembles nine row-major elements into the packed 3x3 matrix bus, waits out the
// determinant stage latency, then hands the returned determinant out over valid/ready.
module matrix_stream_loader #(
   parameter int ELEM_W      = 32,
   parameter int DET_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ELEM_W-1:0]     in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [9*ELEM_W-1:0]   matrix_out,
   input  logic [ELEM_W-1:0]     det_in,
   output logic [ELEM_W-1:0]     det_out,
   output logic                  det_valid,
   input  logic                  det_ready,
   output logic                  frame_err
);

   localparam int MAT_W  = 9 * ELEM_W;
   localparam int WAIT_W = (DET_LATENCY < 1) ? 1 : $clog2(DET_LATENCY + 1);

   typedef enum logic [1:0] {
      S_FILL,
      S_WAIT,
      S_OUT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          elem_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [MAT_W-1:0]    shadow;
   logic                accept;
   logic                last_elem;
   logic                wait_done;

   assign in_ready  = (state == S_FILL) && !reset;
   assign accept    = in_valid && in_ready;
   assign last_elem = (elem_cnt == 4'd8);
   assign wait_done = (wait_cnt == WAIT_W'(DET_LATENCY));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its neighbours, independent of process ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FILL;
      else       state <= state_nxt;
   end

   // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:  if (accept && last_elem)     state_nxt = S_WAIT;
         S_WAIT:  if (wait_done)               state_nxt = S_OUT;
         S_OUT:   if (det_valid && det_ready)  state_nxt = S_FILL;
         default:                              state_nxt = S_FILL;
      endcase
   end

   // NOTE: the shadow buffer is cleared on reset as well, so a discarded partial
   // matrix can never leak into a later matrix_out.
   always_ff @(posedge clk) begin
      if (reset) begin
         elem_cnt   <= '0;
         wait_cnt   <= '0;
         shadow     <= '0;
         matrix_out <= '0;
         det_out    <= '0;
         det_valid  <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            S_FILL: begin
               if (accept) begin
                  for (int k = 0; k < 9; k++) begin
                     if (elem_cnt == 4'(k)) shadow[MAT_W-1-k*ELEM_W -: ELEM_W] <= in_data;
                  end
                  if (last_elem) begin
                     // The 9th element bypasses the shadow so matrix_out updates this edge
                     matrix_out <= {shadow[MAT_W-1:ELEM_W], in_data};
                     elem_cnt   <= '0;
                     wait_cnt   <= '0;
                     frame_err  <= !in_last;
                  end else if (in_last) begin
                     elem_cnt  <= '0;
                     frame_err <= 1'b1;
                  end else begin
                     elem_cnt <= elem_cnt + 4'd1;
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (wait_done) begin
                  det_out   <= det_in;
                  det_valid <= 1'b1;
               end
            end
            S_OUT: begin
               if (det_ready) det_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader; a two-stage determinant stub closes the loop
// between matrix_out and det_in.
module tb_matrix_stream_loader;

   typedef logic [31:0] mat_t [9];

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [287:0]  matrix_out;
   logic [31:0]   det_in;
   logic [31:0]   det_out;
   logic          det_valid;
   logic          det_ready;
   logic          frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   matrix_stream_loader #(.ELEM_W(32), .DET_LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .matrix_out (matrix_out),
      .det_in     (det_in),
      .det_out    (det_out),
      .det_valid  (det_valid),
      .det_ready  (det_ready),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   function automatic int det3(input logic [287:0] m);
      int a, b, c, d, e, f, g, h, i;
      a = m[287:256]; b = m[255:224]; c = m[223:192];
      d = m[191:160]; e = m[159:128]; f = m[127:96];
      g = m[95:64];   h = m[63:32];   i = m[31:0];
      return a*(e*i - f*h) - b*(d*i - f*g) + c*(d*h - e*g);
   endfunction

   // Determinant stage model: two register stages after matrix_out
   logic [31:0] det_s1, det_s2;
   always @(posedge clk) begin
      det_s1 <= det3(matrix_out);
      det_s2 <= det_s1;
   end
   assign det_in = det_s2;

   logic [31:0] hs_q[$];
   int acc_cnt   = 0;
   int fe_cnt    = 0;
   int stall_cnt = 0;
   always @(posedge clk) begin
      if (det_valid && det_ready) hs_q.push_back(det_out);
      if (in_valid && in_ready)   acc_cnt++;
      if (frame_err)              fe_cnt++;
      if (in_valid && !in_ready && !reset) stall_cnt++;
   end

   function automatic logic [287:0] pack(input mat_t e);
      logic [287:0] m;
      for (int k = 0; k < 9; k++) m[287-32*k -: 32] = e[k];
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams n elements, in_last on index last_idx; returns #1 after the final accept edge
   task automatic stream(input mat_t e, input int n, input int last_idx, input bit drop_valid);
      for (int k = 0; k < n; k++) begin
         int cyc;
         in_data  = e[k];
         in_last  = (k == last_idx);
         in_valid = 1'b1;
         cyc = 0;
         while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
         end
         if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout elem=%0d in_ready stayed 0 for %0d cycles", k, cyc);
            return;
         end
         tick();
      end
      in_last = 1'b0;
      if (drop_valid) in_valid = 1'b0;
   endtask

   // Full matrix: layout, latency, value, handshake and frame_err count
   task automatic run_matrix(input string name, input mat_t e, input logic [31:0] exp_det,
                             input int last_idx);
      int fe0, hs0, lat;
      logic [287:0] exp_m;
      fe0   = fe_cnt;
      hs0   = hs_q.size();
      exp_m = pack(e);
      stream(e, 9, last_idx, 1'b1);
      n_checks++;
      if (matrix_out !== exp_m) begin
         n_fail++;
         $display("FAIL %s_matrix_out got=%h exp=%h", name, matrix_out, exp_m);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_after_9th got=%b exp=0", name, in_ready);
      end
      lat = 0;
      while (det_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++;
      if (lat != 3) begin
         n_fail++;
         $display("FAIL %s_latency got=%0d exp=3", name, lat);
      end
      n_checks++;
      if (det_out !== exp_det) begin
         n_fail++;
         $display("FAIL %s_det_out got=%h exp=%h", name, det_out, exp_det);
      end
      tick();
      n_checks++;
      if (det_valid !== 1'b0 || hs_q.size() != hs0 + 1) begin
         n_fail++;
         $display("FAIL %s_handshake det_valid=%b handshakes=%0d exp 0 and %0d",
                  name, det_valid, hs_q.size() - hs0, 1);
      end else if (hs_q[hs0] !== exp_det) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_hs_value got=%h exp=%h", name, hs_q[hs0], exp_det);
      end
      n_checks++;
      if (fe_cnt - fe0 != ((last_idx == 8) ? 0 : 1)) begin
         n_fail++;
         $display("FAIL %s_frame_err pulses got=%0d exp=%0d", name, fe_cnt - fe0,
                  (last_idx == 8) ? 0 : 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; det_ready = 1'b1;
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || matrix_out !== '0 || det_out !== '0 ||
          det_valid !== 1'b0 || frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs in_ready=%b mo_zero=%b det_out=%h dv=%b fe=%b exp all 0",
                  in_ready, matrix_out == '0, det_out, det_valid, frame_err);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_arith();
      run_matrix("identity", '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1},
                 32'd1, 8);
      n_checks++;
      if (matrix_out !== 288'h00000001_00000000_00000000_00000000_00000001_00000000_00000000_00000000_00000001) begin
         n_fail++;
         $display("FAIL identity_layout got=%h", matrix_out);
      end
      run_matrix("seq", '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9},
                 32'd0, 8);
      run_matrix("diag", '{32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd4},
                 32'd24, 8);
      run_matrix("neg", '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1},
                 32'hFFFF_FFFF, 8);
   endtask

   task automatic test_back_to_back();
      int acc0, hs0, st0, cyc;
      det_ready = 1'b1;
      acc0 = acc_cnt; hs0 = hs_q.size(); st0 = stall_cnt;
      stream('{32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd4}, 9, 8, 1'b0);
      stream('{32'd1, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd1}, 9, 8, 1'b0);
      stream('{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1}, 9, 8, 1'b1);
      cyc = 0;
      while (hs_q.size() < hs0 + 3 && cyc < 30) begin
         tick();
         cyc++;
      end
      n_checks++;
      if (acc_cnt - acc0 != 27) begin
         n_fail++;
         $display("FAIL b2b_accepts got=%0d exp=27", acc_cnt - acc0);
      end
      n_checks++;
      if (stall_cnt - st0 != 8) begin
         n_fail++;
         $display("FAIL b2b_stall_cycles got=%0d exp=8", stall_cnt - st0);
      end
      n_checks++;
      if (hs_q.size() != hs0 + 3) begin
         n_fail++;
         $display("FAIL b2b_results got=%0d exp=3", hs_q.size() - hs0);
      end else if (hs_q[hs0] !== 32'd24 || hs_q[hs0+1] !== 32'd5 || hs_q[hs0+2] !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL b2b_values got=%h,%h,%h exp=00000018,00000005,ffffffff",
                  hs_q[hs0], hs_q[hs0+1], hs_q[hs0+2]);
      end
   endtask

   task automatic test_backpressure();
      int hs0, cyc;
      det_ready = 1'b0;
      hs0 = hs_q.size();
      stream('{32'd3, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1}, 9, 8, 1'b1);
      cyc = 0;
      while (det_valid !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (det_valid !== 1'b1 || det_out !== 32'd3 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d dv=%b det_out=%h in_ready=%b exp 1,00000003,0",
                     i, det_valid, det_out, in_ready);
         end
         tick();
      end
      det_ready = 1'b1;
      tick();
      n_checks++;
      if (det_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release dv=%b in_ready=%b exp 0,1", det_valid, in_ready);
      end
      tick(); tick();
      n_checks++;
      if (hs_q.size() != hs0 + 1 || hs_q[$] !== 32'd3) begin
         n_fail++;
         $display("FAIL release_handshakes got=%0d last=%h exp 1 and 00000003",
                  hs_q.size() - hs0, hs_q[$]);
      end
   endtask

   task automatic test_frame_err();
      int fe0, hs0;
      det_ready = 1'b1;
      fe0 = fe_cnt; hs0 = hs_q.size();
      stream('{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 4, 3, 1'b1);
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL early_last_pulse got=%b exp=1", frame_err);
      end
      tick();
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL early_last_pulse_width got=%b exp=0", frame_err);
      end
      repeat (5) tick();
      n_checks++;
      if (hs_q.size() != hs0 || det_valid !== 1'b0 || fe_cnt - fe0 != 1) begin
         n_fail++;
         $display("FAIL early_last_no_det handshakes=%0d dv=%b pulses=%0d exp 0,0,1",
                  hs_q.size() - hs0, det_valid, fe_cnt - fe0);
      end
      run_matrix("after_err", '{32'd2, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0, 32'd4},
                 32'd24, 8);
      run_matrix("missing_last", '{32'd1, 32'd2, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd6},
                 32'd6, 9);
   endtask

   task automatic test_reset_in_wait();
      int hs0;
      det_ready = 1'b1;
      hs0 = hs_q.size();
      stream('{32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5}, 9, 8, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (matrix_out !== '0 || det_out !== '0 || det_valid !== 1'b0 ||
          frame_err !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_reset_outputs mo_zero=%b det_out=%h dv=%b fe=%b rdy=%b exp all 0",
                  matrix_out == '0, det_out, det_valid, frame_err, in_ready);
      end
      reset = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (hs_q.size() != hs0 || det_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_reset_no_det handshakes=%0d dv=%b exp 0,0", hs_q.size() - hs0,
                  det_valid);
      end
      run_matrix("post_reset", '{32'd1, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'd2},
                 32'd8, 8);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_frame_err();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
